// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD..SRA, reserved) produce a result on the accept edge.
// MUL/MULHU (shift-add) and DIVU/REMU (restoring) take WIDTH iterations.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  operation handshake (ALUctrl, ALUop1, ALUop2)
//   out_valid, out_ready result handshake (ALUout, EQ, Zero)
//   ALUout              result
//   EQ                  accepted ALUop1 == ALUop2, registered with the result
//   Zero                ALUout == 0
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctrl,
  input  logic [WIDTH-1:0] ALUop1,
  input  logic [WIDTH-1:0] ALUop2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUout,
  output logic             EQ,
  output logic             Zero
);

  localparam int unsigned CW = SHW + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic               is_div_q, is_div_d;
  logic               hi_q, hi_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               eq_q, eq_d;

  logic               accept;
  logic               iterative;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   fast_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign iterative = (ALUctrl >= 4'd10) && (ALUctrl <= 4'd13);
  assign shamt     = ALUop2[SHW-1:0];

  assign out_valid = (state_q == StDone);
  assign ALUout    = result_q;
  assign EQ        = eq_q;
  assign Zero      = (result_q == '0);

  always_comb begin
    fast_res = '0;
    case (ALUctrl)
      4'd0:    fast_res = ALUop1 + ALUop2;
      4'd1:    fast_res = ALUop1 - ALUop2;
      4'd2:    fast_res = ALUop1 & ALUop2;
      4'd3:    fast_res = ALUop1 | ALUop2;
      4'd4:    fast_res = ALUop1 ^ ALUop2;
      4'd5:    fast_res = {{(WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      4'd6:    fast_res = {{(WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
      4'd7:    fast_res = ALUop1 << shamt;
      4'd8:    fast_res = ALUop1 >> shamt;
      4'd9:    fast_res = $unsigned($signed(ALUop1) >>> shamt);
      default: fast_res = '0;
    endcase
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; add op2 into the
  // upper half when the current multiplier bit is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? op2_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend bits / quotient bits}; shift left and
  // subtract the divisor when it fits. A zero divisor always "fits", which yields
  // an all-ones quotient and leaves the dividend in the remainder.
  assign div_ge   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, op2_q};
  assign div_diff = acc_q[2*WIDTH-2:WIDTH-1] - op2_q;
  assign div_next = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};

  assign step_next = is_div_q ? div_next : mul_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    result_d = result_q;
    eq_d     = eq_q;
    case (state_q)
      StBusy: begin
        acc_d = step_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // MULHU and REMU take the upper half of the accumulator.
          result_d = hi_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
          eq_d     = (op1_q == op2_q);
          state_d  = StDone;
        end
      end
      default: begin
        if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
        if (accept) begin
          if (iterative) begin
            op1_d    = ALUop1;
            op2_d    = ALUop2;
            is_div_d = ALUctrl[2];
            hi_d     = ALUctrl[0];
            acc_d    = {{WIDTH{1'b0}}, ALUop1};
            cnt_d    = CW'(WIDTH);
            state_d  = StBusy;
          end else begin
            result_d = fast_res;
            eq_d     = (ALUop1 == ALUop2);
            state_d  = StDone;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= 1'b0;
      result_q <= '0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      eq_q     <= eq_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32). Inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUctrl;
  logic [31:0] ALUop1;
  logic [31:0] ALUop2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUout;
  logic        EQ;
  logic        Zero;

  int n_checks;
  int n_pass;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUctrl   (ALUctrl),
    .ALUop1    (ALUop1),
    .ALUop2    (ALUop2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .EQ        (EQ),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op from an idle handshake and wait for its result, leaving it
  // pending (out_ready=0). exp_edges counts rising edges after the accept edge
  // before out_valid is seen: 0 for single-cycle ops, 32 for iterative ones.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int exp_edges,
                        input logic [31:0] exp_res, input logic exp_eq);
    int  edges;
    logic rdy_in_busy;
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    ALUctrl  = c;
    ALUop1   = a;
    ALUop2   = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    ALUop1   = 32'hDEAD_BEEF;
    ALUop2   = 32'h1234_5678;
    edges       = 0;
    rdy_in_busy = 1'b0;
    while (!out_valid && edges < 100) begin
      if (in_ready) rdy_in_busy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, edges, exp_edges);
    check({tag, " in_ready low while busy"}, {31'd0, rdy_in_busy}, 32'd0);
    check({tag, " result"}, ALUout, exp_res);
    check({tag, " EQ"}, {31'd0, EQ}, {31'd0, exp_eq});
    check({tag, " Zero"}, {31'd0, Zero}, {31'd0, (exp_res == 32'd0)});
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after take"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic seen_valid;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    ALUctrl   = 4'd0;
    ALUop1    = 32'd0;
    ALUop2    = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset ALUout", ALUout, 32'd0);
    check("reset EQ", {31'd0, EQ}, 32'd0);
    check("reset Zero", {31'd0, Zero}, 32'd1);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    run_op("ADD wrap", 4'd0, 32'h7FFF_FFFF, 32'h1, 0, 32'h8000_0000, 1'b0);
    consume("ADD wrap");
    run_op("SUB 5-5", 4'd1, 32'd5, 32'd5, 0, 32'd0, 1'b1);
    consume("SUB 5-5");
    run_op("SLT", 4'd5, 32'hFFFF_FFFF, 32'd1, 0, 32'd1, 1'b0);
    consume("SLT");
    run_op("SLTU", 4'd6, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 1'b0);
    consume("SLTU");
    run_op("SRA", 4'd9, 32'h8000_0000, 32'h21, 0, 32'hC000_0000, 1'b0);
    consume("SRA");
    run_op("SRL", 4'd8, 32'h8000_0000, 32'h24, 0, 32'h0800_0000, 1'b0);
    consume("SRL");
    run_op("SLL", 4'd7, 32'h0000_00F1, 32'd8, 0, 32'h0000_F100, 1'b0);
    consume("SLL");
    run_op("OR", 4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 0, 32'hF0F0_0F0F, 1'b0);
    consume("OR");
    run_op("XOR", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 0, 32'h5555_5555, 1'b0);
    consume("XOR");
    run_op("reserved", 4'd14, 32'h1234_5678, 32'h1234_5678, 0, 32'd0, 1'b1);
    consume("reserved");

    run_op("MUL", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0001, 1'b1);
    consume("MUL");
    run_op("MULHU", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, 1'b1);
    consume("MULHU");
    run_op("MUL small", 4'd10, 32'd12345, 32'd678, 32, 32'd8369910, 1'b0);
    consume("MUL small");
    run_op("DIVU", 4'd12, 32'd100, 32'd7, 32, 32'd14, 1'b0);
    consume("DIVU");
    run_op("REMU", 4'd13, 32'd100, 32'd7, 32, 32'd2, 1'b0);
    consume("REMU");
    run_op("DIVU by 0", 4'd12, 32'd9, 32'd0, 32, 32'hFFFF_FFFF, 1'b0);
    consume("DIVU by 0");
    run_op("REMU by 0", 4'd13, 32'd9, 32'd0, 32, 32'd9, 1'b0);
    consume("REMU by 0");

    // Back-pressure: result must hold while out_ready=0, then same-edge handoff.
    run_op("ADD hold", 4'd0, 32'd40, 32'd2, 0, 32'd42, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold out_valid", {31'd0, out_valid}, 32'd1);
      check("hold ALUout", ALUout, 32'd42);
      check("hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ALUctrl   = 4'd2;
    ALUop1    = 32'hF0;
    ALUop2    = 32'h3C;
    #1;
    check("handoff in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("handoff out_valid", {31'd0, out_valid}, 32'd1);
    check("handoff AND result", ALUout, 32'h30);
    consume("AND handoff");

    // Reset in the middle of a divide discards it.
    @(negedge clk);
    in_valid = 1'b1;
    ALUctrl  = 4'd12;
    ALUop1   = 32'd1000;
    ALUop2   = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-reset ALUout", ALUout, 32'd0);
    check("mid-reset Zero", {31'd0, Zero}, 32'd1);
    check("mid-reset in_ready", {31'd0, in_ready}, 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("discarded divide never presented", {31'd0, seen_valid}, 32'd0);
    run_op("ADD after reset", 4'd0, 32'd2, 32'd3, 0, 32'd5, 1'b0);
    consume("ADD after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the reduced RISC-V datapath.
- Successor to the single-cycle add/compare ALU:
  - generic WIDTH;
  - full 4-bit operation set;
  - iterative multiply and unsigned divide;
  - valid/ready handshakes on both input and output.
- Sits between the register-file read stage and writeback. The control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits. Power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and ALUctrl valid this cycle
- in_ready  output  1  block can accept an operation this cycle
- ALUctrl  input  4  operation select
- ALUop1  input  WIDTH  operand 1
- ALUop2  input  WIDTH  operand 2
- out_valid  output  1  ALUout/EQ/Zero hold a completed result
- out_ready  input  1  consumer takes the result this cycle
- ALUout  output  WIDTH  result
- EQ  output  1  accepted ALUop1 == ALUop2, registered with the result
- Zero  output  1  ALUout == 0

Behaviour:
- Reset: rst high at a rising edge forces state IDLE and sets out_valid=0, ALUout=0, EQ=0, Zero=1, counter=0, internal accumulators=0.
  - Reset overrides any in-flight operation; a partial result is discarded and never presented.
- Handshake:
  - Accept = in_valid && in_ready at a rising edge.
  - Result transfer = out_valid && out_ready at a rising edge.
  - ALUout, EQ and Zero hold stable while out_valid=1 and out_ready=0.
  - Inputs are sampled only on accept.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back operation with no bubble.
- ALUctrl encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU: result 1 or 0, zero-extended.
  - 7 SLL, 8 SRL, 9 SRA: shift amount = ALUop2[SHW-1:0], upper bits ignored.
  - 10 MUL: low WIDTH bits of the unsigned product.
  - 11 MULHU: high WIDTH bits of the unsigned product.
  - 12 DIVU, 13 REMU.
  - 14, 15 reserved: result 0, single-cycle.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH; there is no overflow flag.
- States: IDLE, BUSY, DONE.
  - IDLE + accept of a single-cycle op (0-9, 14, 15): compute, register ALUout/EQ/Zero, go to DONE. out_valid=1 after the accept edge (latency 1).
  - IDLE + accept of an iterative op (10-13): latch operands and ALUctrl, load counter=WIDTH, go to BUSY. out_valid stays 0.
  - BUSY: one iteration per cycle.
    - MUL/MULHU use shift-add on a 2*WIDTH-bit accumulator.
    - DIVU/REMU use restoring division, one quotient bit per cycle.
    - Counter decrements; the edge that performs the last iteration registers the result and moves to DONE.
    - Latency from the accept edge to out_valid=1 is exactly WIDTH cycles.
    - in_valid is ignored in BUSY.
  - DONE, out_ready=0: hold.
  - DONE, out_ready=1, no accept: go to IDLE, out_valid=0.
  - DONE, out_ready=1, accept: behave as an accept from IDLE on the same edge. A single-cycle op stays in DONE with the new result; an iterative op goes to BUSY with out_valid=0.
- Divide by zero: DIVU gives all ones, REMU gives ALUop1. Latency is still WIDTH; no exception is raised.
- Zero is derived from the registered ALUout. EQ is computed for every op from the latched operands.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 -> after 1 cycle out_valid=1, ALUout=0x80000000, EQ=0, Zero=0. Then SUB 5-5 -> ALUout=0, Zero=1, EQ=1.
- SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by ALUop2=0x21 -> shift 1, result 0xC0000000.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> out_valid exactly 32 cycles after accept, ALUout=0x00000001, in_ready=0 throughout BUSY. MULHU same operands -> 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9. Each has 32-cycle latency.
- Hold out_ready=0 for 5 cycles after an ADD result -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND 0xF0&0x3C) -> same-edge handoff, next ALUout=0x30, no bubble.
- Assert rst at cycle 10 of a DIVU -> next cycle state IDLE, out_valid=0, ALUout=0, Zero=1. Subsequent ADD 2+3 -> 5.
